pcs_rx: RTL and testbench

PCS_RX -- requirements
Module: pcs_rx

---
 rtl/pcs_rx.sv | 184 ++++++++++++++++++
 tb/tb_pcs_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx.sv
// 100BASE-X receive PCS: finds /J/K/ in the descrambled bit stream, decodes 4B/5B
// groups onto an MII-style nibble interface and reports false carrier.
module pcs_rx #(
    parameter int FALSE_CARRIER_IDLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bits,
    input  logic [1:0] bits_valid,
    input  logic       locked,
    output logic [3:0] rxd,
    output logic       rxd_valid,
    output logic       rx_dv,
    output logic       rx_er,
    output logic       crs
);
    localparam int         CW = $clog2(FALSE_CARRIER_IDLES + 1);
    localparam logic [9:0] JK = 10'b1100010001;

    typedef enum logic [2:0] {IDLE, CAPTURE, DATA, END, FALSE_CARRIER} state_t;

    // Bit-level state plus the events raised while consuming this cycle's bits.
    typedef struct packed {
        state_t          state;
        logic [9:0]      window;
        logic [3:0]      cnt;
        logic [CW-1:0]   ones;
        logic            strobe;
        logic            err;
        logic [3:0]      data;
        logic            jk;
        logic            close;
        logic            close_next;
    } step_t;

    state_t        state;
    logic [9:0]    window;
    logic [3:0]    cnt;
    logic [CW-1:0] ones;
    logic          jk_pend;
    logic          drop_pend;
    step_t         cur, mid, nxt;

    // Returns {valid, nibble}.
    function automatic logic [4:0] decode(input logic [4:0] g);
        case (g)
            5'b11110: return 5'h10;  5'b01001: return 5'h11;
            5'b10100: return 5'h12;  5'b10101: return 5'h13;
            5'b01010: return 5'h14;  5'b01011: return 5'h15;
            5'b01110: return 5'h16;  5'b01111: return 5'h17;
            5'b10010: return 5'h18;  5'b10011: return 5'h19;
            5'b10110: return 5'h1A;  5'b10111: return 5'h1B;
            5'b11010: return 5'h1C;  5'b11011: return 5'h1D;
            5'b11100: return 5'h1E;  5'b11101: return 5'h1F;
            default:  return 5'h00;
        endcase
    endfunction

    function automatic logic split_zeros(input logic [9:0] w);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int j = i + 2; j < 10; j++)
                if (!w[i] && !w[j]) hit = 1'b1;
        return hit;
    endfunction

    function automatic step_t step(input step_t s, input logic b);
        step_t      n;
        logic [4:0] dec;
        n        = s;
        n.window = {s.window[8:0], b};
        dec      = decode(n.window[4:0]);
        case (s.state)
            IDLE: if (!b) begin
                n.state = CAPTURE;
                n.cnt   = '0;
            end
            CAPTURE: begin
                n.cnt = s.cnt + 4'd1;
                if (n.cnt == 4'd7) begin
                    n.cnt = '0;
                    if (n.window == JK) begin
                        n.state = DATA;
                        n.jk    = 1'b1;
                    end else if (split_zeros(n.window)) begin
                        n.state = FALSE_CARRIER;
                        n.ones  = '0;
                    end else begin
                        n.state = IDLE;
                    end
                end
            end
            DATA, END: begin
                n.cnt = s.cnt + 4'd1;
                if (n.cnt == 4'd5) begin
                    n.cnt = '0;
                    if (s.state == END) begin
                        n.state = IDLE;
                        if (n.window[4:0] == 5'b00111) begin
                            n.close = 1'b1;
                        end else begin
                            n.strobe = 1'b1; n.err = 1'b1; n.data = '0; n.close_next = 1'b1;
                        end
                    end else if (dec[4]) begin
                        n.strobe = 1'b1; n.err = 1'b0; n.data = dec[3:0];
                    end else if (n.window[4:0] == 5'b01101) begin
                        n.state = END;
                    end else if (n.window[4:0] == 5'b11111) begin
                        n.strobe = 1'b1; n.err = 1'b1; n.data = '0; n.close_next = 1'b1;
                        n.state  = IDLE;
                    end else begin
                        n.strobe = 1'b1; n.err = 1'b1; n.data = '0;
                    end
                end
            end
            FALSE_CARRIER: begin
                if (b) begin
                    n.ones = s.ones + CW'(1);
                    if (n.ones == CW'(FALSE_CARRIER_IDLES)) begin
                        n.state = IDLE;
                        n.ones  = '0;
                        n.close = 1'b1;
                    end
                end else begin
                    n.ones = '0;
                end
            end
            default: n.state = IDLE;
        endcase
        return n;
    endfunction

    // NOTE: both bits of a cycle are folded through step() with blocking semantics,
    // so a bit that finishes one state is seen by the next state in the same cycle.
    always_comb begin
        cur        = '0;
        cur.state  = state;
        cur.window = window;
        cur.cnt    = cnt;
        cur.ones   = ones;
        mid = (bits_valid == 2'b01 || bits_valid == 2'b10) ? step(cur, bits[1]) : cur;
        nxt = (bits_valid == 2'b10) ? step(mid, bits[0]) : mid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;  window <= '1;  cnt <= '0;  ones <= '0;
            jk_pend <= 1'b0;  drop_pend <= 1'b0;
            rxd <= '0;  rxd_valid <= 1'b0;  rx_dv <= 1'b0;  rx_er <= 1'b0;  crs <= 1'b0;
        end else if (!locked) begin
            state <= IDLE;  window <= '1;  cnt <= '0;  ones <= '0;
            jk_pend <= 1'b0;  drop_pend <= 1'b0;
            rxd <= '0;  rxd_valid <= 1'b0;  rx_dv <= 1'b0;  rx_er <= 1'b0;  crs <= 1'b0;
        end else begin
            state     <= nxt.state;
            window    <= nxt.window;
            cnt       <= nxt.cnt;
            ones      <= nxt.ones;
            jk_pend   <= nxt.jk;
            drop_pend <= nxt.close_next;
            rxd_valid <= 1'b0;
            rx_er     <= (nxt.state == FALSE_CARRIER);
            if (drop_pend) begin
                rx_dv <= 1'b0;  crs <= 1'b0;  rxd <= '0;
            end
            if (jk_pend) begin
                rxd_valid <= 1'b1;  rxd <= 4'b0101;
            end
            if (nxt.jk) begin
                rxd_valid <= 1'b1;  rxd <= 4'b0101;  rx_dv <= 1'b1;  crs <= 1'b1;
            end
            if (nxt.strobe) begin
                rxd_valid <= 1'b1;  rxd <= nxt.data;  rx_er <= nxt.err;
            end
            if (nxt.close) begin
                rx_dv <= 1'b0;  crs <= 1'b0;  rxd <= '0;
            end
            if (nxt.state == FALSE_CARRIER && state != FALSE_CARRIER) begin
                crs <= 1'b1;  rx_dv <= 1'b0;  rxd <= 4'b1110;
            end
        end
    end
endmodule

// File: tb/tb_pcs_rx.sv
// Bench for pcs_rx: expected strobes are queued as frames are driven and
// compared by a monitor when rxd_valid is seen; per-test level checks are inline.
module tb_pcs_rx;
    localparam logic [9:0] JK = 10'b1100010001;
    localparam logic [4:0] D6 = 5'b01110;
    localparam logic [4:0] D1 = 5'b01001;
    localparam logic [4:0] TT = 5'b01101;
    localparam logic [4:0] RR = 5'b00111;
    localparam logic [63:0] ONES = '1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bits = 2'b00;
    logic [1:0] bits_valid = 2'b00;
    logic       locked = 1'b1;
    logic [3:0] rxd;
    logic       rxd_valid, rx_dv, rx_er, crs;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;

    always #5 clk = ~clk;

    pcs_rx #(.FALSE_CARRIER_IDLES(10)) dut (
        .clk(clk), .rst_n(rst_n), .bits(bits), .bits_valid(bits_valid), .locked(locked),
        .rxd(rxd), .rxd_valid(rxd_valid), .rx_dv(rx_dv), .rx_er(rx_er), .crs(crs)
    );

    // Scoreboard: every strobe must match the oldest queued {rxd, rx_dv, rx_er}.
    always @(negedge clk) begin
        if (rst_n && rxd_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_strobe got=%b want=none", {rxd, rx_dv, rx_er});
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rxd, rx_dv, rx_er} !== mon_exp)
                    $display("FAIL strobe got=%b want=%b", {rxd, rx_dv, rx_er}, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    task automatic push(input logic [3:0] nib, input logic er);
        exp_q.push_back({nib, 1'b1, er});
    endtask

    // Drives n bits of pat, MSB first, w bits per cycle; returns #1 after the last edge.
    task automatic send(input logic [63:0] pat, input int n, input int w);
        int i;
        i = n - 1;
        while (i >= 0) begin
            if (w == 2 && i >= 1) begin
                bits = {pat[i], pat[i-1]};  bits_valid = 2'b10;  i -= 2;
            end else begin
                bits = {pat[i], 1'b0};      bits_valid = 2'b01;  i -= 1;
            end
            @(posedge clk); #1;
        end
        bits_valid = 2'b00;
        bits = 2'b00;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_pending got=%0d want=0", name, exp_q.size());
            exp_q.delete();
        end else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (rxd !== 4'b0000) $display("FAIL reset_rxd got=%b want=0000", rxd); else n_pass++;
        n_checks++; if (rxd_valid !== 1'b0) $display("FAIL reset_rxd_valid got=%b want=0", rxd_valid); else n_pass++;
        n_checks++; if (rx_dv !== 1'b0) $display("FAIL reset_rx_dv got=%b want=0", rx_dv); else n_pass++;
        n_checks++; if (rx_er !== 1'b0) $display("FAIL reset_rx_er got=%b want=0", rx_er); else n_pass++;
        n_checks++; if (crs !== 1'b0) $display("FAIL reset_crs got=%b want=0", crs); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_frame_1bit;
        push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h6, 1'b0); push(4'h1, 1'b0);
        send(ONES, 12, 1);
        send({JK, D6, D1}, 20, 1);
        n_checks++; if ({crs, rx_dv} !== 2'b11) $display("FAIL f1_in_frame got=%b want=11", {crs, rx_dv}); else n_pass++;
        send({TT, RR}, 10, 1);
        send(ONES, 4, 1);
        n_checks++; if ({crs, rx_dv} !== 2'b00) $display("FAIL f1_after_r got=%b want=00", {crs, rx_dv}); else n_pass++;
        check_drained("f1");
    endtask

    task automatic test_frame_2bit;
        push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h6, 1'b0); push(4'h1, 1'b0);
        send({11'h7FF, JK, D6, D1, TT, RR, 1'b1}, 42, 2);
        send(ONES, 4, 2);
        n_checks++; if ({crs, rx_dv} !== 2'b00) $display("FAIL f2_after_r got=%b want=00", {crs, rx_dv}); else n_pass++;
        check_drained("f2");
    endtask

    task automatic test_false_carrier;
        send(ONES, 12, 1);
        send(10'b1100110011, 10, 1);
        n_checks++; if ({crs, rx_er, rx_dv} !== 3'b110) $display("FAIL fc_flags got=%b want=110", {crs, rx_er, rx_dv}); else n_pass++;
        n_checks++; if (rxd !== 4'b1110) $display("FAIL fc_rxd got=%b want=1110", rxd); else n_pass++;
        send(ONES, 5, 1);
        send(64'd0, 1, 1);
        send(ONES, 9, 1);
        n_checks++; if ({crs, rx_er} !== 2'b11) $display("FAIL fc_restart got=%b want=11", {crs, rx_er}); else n_pass++;
        send(ONES, 1, 1);
        n_checks++; if ({crs, rx_er} !== 2'b00) $display("FAIL fc_exit got=%b want=00", {crs, rx_er}); else n_pass++;
        n_checks++; if (rxd !== 4'b0000) $display("FAIL fc_exit_rxd got=%b want=0000", rxd); else n_pass++;
    endtask

    task automatic test_no_carrier;
        send(ONES, 12, 1);
        send({10'b1101111111, 4'hF}, 14, 1);
        n_checks++; if ({crs, rx_er} !== 2'b00) $display("FAIL nc_flags got=%b want=00", {crs, rx_er}); else n_pass++;
    endtask

    task automatic test_idle_group;
        push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h6, 1'b0); push(4'h0, 1'b1);
        send(ONES, 12, 1);
        send({JK, D6, 5'b11111}, 20, 1);
        n_checks++; if ({rxd_valid, rx_dv, rx_er} !== 3'b111) $display("FAIL ig_strobe got=%b want=111", {rxd_valid, rx_dv, rx_er}); else n_pass++;
        send(ONES, 1, 1);
        n_checks++; if ({crs, rx_dv} !== 2'b00) $display("FAIL ig_drop got=%b want=00", {crs, rx_dv}); else n_pass++;
        send(ONES, 4, 1);
        check_drained("ig");
    endtask

    task automatic test_bad_group;
        push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h0, 1'b1); push(4'h1, 1'b0);
        send(ONES, 12, 1);
        send({JK, 5'b00000, D1}, 20, 1);
        n_checks++; if ({crs, rx_dv} !== 2'b11) $display("FAIL bg_stays got=%b want=11", {crs, rx_dv}); else n_pass++;
        send({TT, RR, 4'hF}, 14, 1);
        n_checks++; if ({crs, rx_dv} !== 2'b00) $display("FAIL bg_after_r got=%b want=00", {crs, rx_dv}); else n_pass++;
        check_drained("bg");
    endtask

    task automatic test_lock_drop;
        push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h6, 1'b0);
        send(ONES, 12, 1);
        send({JK, D6, 3'b011}, 18, 1);
        locked = 1'b0;  bits = 2'b01;  bits_valid = 2'b10;
        @(posedge clk); #1;
        locked = 1'b1;  bits_valid = 2'b00;
        n_checks++; if ({crs, rx_dv, rxd_valid} !== 3'b000) $display("FAIL ld_clear got=%b want=000", {crs, rx_dv, rxd_valid}); else n_pass++;
        send(ONES, 12, 1);
        check_drained("ld_quiet");
        push(4'h5, 1'b0); push(4'h5, 1'b0); push(4'h1, 1'b0);
        send({JK, D1, TT, RR}, 25, 2);
        send(ONES, 4, 2);
        n_checks++; if ({crs, rx_dv} !== 2'b00) $display("FAIL ld_reframe got=%b want=00", {crs, rx_dv}); else n_pass++;
        check_drained("ld");
    endtask

    task automatic test_reset_mid_frame;
        push(4'h5, 1'b0); push(4'h5, 1'b0);
        send(ONES, 12, 1);
        send({JK, 2'b01}, 12, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send({3'b110, 7'h7F}, 10, 1);
        send(ONES, 12, 1);
        n_checks++; if ({crs, rx_dv} !== 2'b00) $display("FAIL rm_quiet got=%b want=00", {crs, rx_dv}); else n_pass++;
        check_drained("rm");
    endtask

    initial begin
        test_reset();
        test_frame_1bit();
        test_frame_2bit();
        test_false_carrier();
        test_no_carrier();
        test_idle_group();
        test_bad_group();
        test_lock_drop();
        test_reset_mid_frame();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
